// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and the ALU arbiter.
//   alu_op_t    : 2-bit ALU operation code (ADD/SUB/AND/OR)
//   arb_state_t : arbiter FSM state (IDLE/EXEC/RESP)
//   ALU_W       : datapath width of the shared ALU
package alu_pkg;

    localparam int unsigned ALU_W = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU shared by the issue-side requesters.
// Ports:
//   A, B     : operands
//   ALU_Sel  : operation select (alu_op_t)
//   ALU_Out  : result, modulo 2^ALU_W (carry/borrow discarded)
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  alu_op_t          ALU_Sel,
    output logic [ALU_W-1:0] ALU_Out
);

    always_comb begin
        ALU_Out = '0;
        case (ALU_Sel)
            OP_ADD:  ALU_Out = A + B;
            OP_SUB:  ALU_Out = A - B;
            OP_AND:  ALU_Out = A & B;
            OP_OR:   ALU_Out = A | B;
            default: ALU_Out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req        : request vector, one bit per requester
//   last_grant : index of the most recently granted requester
//   grant      : one-hot grant (zero when no request)
//   idx        : binary index of the granted requester
//   found      : at least one request present
// The search starts one past last_grant and wraps modulo NREQ, so the
// previous winner has the lowest priority on the next pick.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_grant) + k) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = IDXW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// Ports:
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   req_valid  : per-requester request present
//   req_ready  : per-requester request accepted (IDLE only, at most one bit)
//   req_a/b    : packed operands, requester i at [i*W +: W]
//   req_op     : packed op codes, requester i at [i*2 +: 2]
//   rsp_valid  : result valid to the granted requester (one-hot or zero)
//   rsp_ready  : requester accepts the result (only the winner's bit counts)
//   rsp_data   : shared result bus, qualified by rsp_valid
//   busy       : FSM is in EXEC or RESP
//   op_count   : completed responses, wraps at 16 bits
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = ALU_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              busy,
    output logic [15:0]       op_count
);

    localparam int unsigned     IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_LSB = NREQ'(1);

    arb_state_t      state;
    logic [IDXW-1:0] last_grant;
    logic [IDXW-1:0] cap_idx;
    logic [W-1:0]    cap_a;
    logic [W-1:0]    cap_b;
    alu_op_t         cap_op;

    logic [NREQ-1:0] pick_grant;
    logic [IDXW-1:0] pick_idx;
    logic            pick_found;
    logic [W-1:0]    alu_out;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .idx        (pick_idx),
        .found      (pick_found)
    );

    // ALU inputs come only from the capture registers, so they change
    // solely on a request handshake.
    alu u_alu (
        .A       (cap_a),
        .B       (cap_b),
        .ALU_Sel (cap_op),
        .ALU_Out (alu_out)
    );

    always_comb begin
        req_ready = '0;
        if (state == IDLE) begin
            req_ready = pick_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDXW'(NREQ - 1);
            cap_idx    <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_op     <= OP_ADD;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        cap_a      <= req_a[pick_idx*W +: W];
                        cap_b      <= req_b[pick_idx*W +: W];
                        cap_op     <= alu_op_t'(req_op[pick_idx*2 +: 2]);
                        cap_idx    <= pick_idx;
                        last_grant <= pick_idx;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_valid <= ONE_LSB << cap_idx;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[cap_idx]) begin
                        rsp_valid <= '0;
                        op_count  <= op_count + 16'd1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single instance of the team's 16-bit `alu` between `NREQ` requesters. Each requester presents operands and an op code on a valid/ready request channel. The arbiter picks one round-robin, registers the operands, drives the ALU for one cycle and registers the result. It then returns the result on that requester's valid/ready response channel. It sits between the instruction-side issue logic and the shared ALU datapath, and is the only block that drives the ALU's `A`, `B` and `ALU_Sel` inputs.

## Interface
- `NREQ`, default 2: number of requesters, range 2..8.
- `W`, default 16: operand/result width; must equal the ALU width.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req_valid` input NREQ: request present, one bit per requester.
- `req_ready` output NREQ: request accepted this cycle; at most one bit set.
- `req_a` input NREQ*W: operand A; requester i uses slice [i*W +: W].
- `req_b` input NREQ*W: operand B, sliced the same way.
- `req_op` input NREQ*2: op code; requester i uses slice [i*2 +: 2]. 0 ADD, 1 SUB, 2 AND, 3 OR.
- `rsp_valid` output NREQ: result valid to the granted requester; one-hot or zero.
- `rsp_ready` input NREQ: requester accepts the result.
- `rsp_data` output W: result, shared by all requesters; qualified by `rsp_valid`.
- `busy` output 1: high in any state other than IDLE.
- `op_count` output 16: count of completed responses; wraps from 0xFFFF to 0x0000.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:** the arbiter selects a winner from `req_valid`.
  - Search starts at `last_grant+1` modulo NREQ and takes the first set bit.
  - `req_ready[winner]` is driven combinationally from `req_valid` and `last_grant`.
  - On the handshake the arbiter captures a, b, op and the winner index, updates `last_grant`, and moves to EXEC.
  - With no valid request it stays in IDLE.
- **EXEC:** the ALU is driven from the captured registers. `ALU_Out` is registered into `rsp_data`, then the FSM moves to RESP.
- **RESP:** `rsp_valid[winner]` is held, together with a stable `rsp_data`, until `rsp_ready[winner]` is high.
  - On that handshake `op_count` increments and the FSM returns to IDLE.
  - `rsp_ready` bits of non-winning requesters are ignored.
- No new request is accepted in EXEC or RESP; `req_ready` is all zeros there.
- Arithmetic is modulo 2^W. Carry and borrow are discarded.
- The ALU is combinational. Its inputs hold the captured values in every state and change only on a new request handshake.
- Requesters must not make `req_valid` depend on `req_ready`. Once `req_valid` is asserted, it and its payload stay stable until the handshake.

## Timing
- **Reset values:** state IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `op_count`=0, `last_grant`=NREQ-1 (so requester 0 wins first), captured operands and op = 0.
- **Latency:** request handshake at edge T; EXEC during cycle T+1; `rsp_valid` high from cycle T+2.
- **Throughput:** one operation per 3 cycles when responses are accepted immediately. A response stalled for k cycles adds k cycles.
- **Simultaneous requests:** exactly one is granted per IDLE cycle. A requester that keeps `req_valid` high is served within NREQ grants, so no requester starves.
- A response handshake and a new request are never accepted in the same cycle; IDLE is always passed through.
- **Reset mid-operation:** a sync reset during EXEC or RESP aborts the operation. No response is issued and `op_count` is not incremented.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_t` (2-bit enum ADD/SUB/AND/OR), shared with `alu`;
  - `arb_state_t` (IDLE/EXEC/RESP);
  - `ALU_W` = 16.
- Sub-module `rr_pick` is a combinational round-robin picker. Inputs: request vector and `last_grant`. Outputs: one-hot grant and binary index.
- `alu` is instantiated once inside `alu_arbiter`.

## Test plan
- **Single ADD:** requester 0 sends a=0x00FA, b=0x0002, op ADD.
  - Expect `req_ready[0]` in the same cycle, then `rsp_valid[0]` 2 cycles later with `rsp_data`=0x00FC.
  - Expect `op_count`=1 after `rsp_ready`.
- **All ops:** requester 1 sends a=0x00FA, b=0x0002 with ops SUB, AND, OR in sequence. Expect 0x00F8, 0x0002, 0x00FA, each with 3-cycle spacing.
- **Wrap-around:** ADD 0xFFFF+0x0001 gives 0x0000. SUB 0x0000-0x0001 gives 0xFFFF.
- **Contention:** both requesters hold valid continuously.
  - Grants alternate 0,1,0,1; requester 0 is first after reset.
  - Each `rsp_data` matches its own requester's operands.
- **Response backpressure:** hold `rsp_ready[0]` low for 5 cycles.
  - `rsp_valid` and `rsp_data` stay stable, `req_ready` stays 0, `busy` stays 1.
  - The response completes on the cycle `rsp_ready` rises.
- **Reset in EXEC/RESP:** assert `rst_n`=0 for one edge while in EXEC or RESP.
  - All outputs return to reset values and no `rsp_valid` appears.
  - The next grant goes to requester 0.
